// File: rtl/pass_memory_server.sv
// Sequences the image passes one at a time and owns the single image RAM port,
// forwarding the enabled pass's bus while guarding against runaway passes and out-of-range writes.
module pass_memory_server #(
    parameter int          NUM_PASSES     = 4,
    parameter int          IMAGE_WORDS    = 76800,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                  clk_div_by_two,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [NUM_PASSES-1:0] pass_enable,
    input  logic [NUM_PASSES-1:0] pass_done,
    input  logic                  bus_wren,
    input  logic [17:0]           bus_address,
    input  logic [31:0]           bus_data_write,
    output logic                  ram_wren,
    output logic [17:0]           ram_address,
    output logic [31:0]           ram_data_write,
    input  logic [31:0]           ram_data_read,
    output logic [31:0]           data_read,
    output logic [7:0]            current_pass,
    output logic                  sequence_busy,
    output logic                  sequence_done,
    output logic [17:0]           write_count,
    output logic                  timeout_error,
    output logic                  range_error
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RUN      = 3'd1;
    localparam logic [2:0] ST_GAP      = 3'd2;
    localparam logic [2:0] ST_FINISHED = 3'd3;
    localparam logic [2:0] ST_ABORT    = 3'd4;

    localparam logic [18:0] ADDR_LIMIT     = 19'(IMAGE_WORDS);
    localparam logic [7:0]  LAST_PASS      = 8'(NUM_PASSES - 1);
    localparam logic [23:0] WATCHDOG_LIMIT = TIMEOUT_CYCLES - 24'd1;
    localparam logic [17:0] COUNT_MAX      = 18'h3FFFF;

    logic [2:0]  state;
    logic [23:0] watchdog;
    logic        hold_cycle;
    logic        in_run;
    logic        addr_in_range;
    logic        done_hit;
    logic        watchdog_expired;

    assign in_run           = (state == ST_RUN);
    assign addr_in_range    = ({1'b0, bus_address} < ADDR_LIMIT);
    // pass_enable is one-hot on the current pass while running, so it selects the right done bit
    assign done_hit         = |(pass_done & pass_enable);
    assign watchdog_expired = (watchdog == WATCHDOG_LIMIT);

    assign ram_wren       = in_run & bus_wren & addr_in_range;
    assign ram_address    = in_run ? bus_address : 18'd0;
    assign ram_data_write = in_run ? bus_data_write : 32'd0;
    assign data_read      = ram_data_read;

    always_ff @(posedge clk_div_by_two or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            watchdog      <= 24'd0;
            hold_cycle    <= 1'b0;
            pass_enable   <= '0;
            current_pass  <= 8'd0;
            sequence_busy <= 1'b0;
            sequence_done <= 1'b0;
            write_count   <= 18'd0;
            timeout_error <= 1'b0;
            range_error   <= 1'b0;
        end else begin
            sequence_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_RUN;
                        pass_enable   <= NUM_PASSES'(1);
                        current_pass  <= 8'd0;
                        watchdog      <= 24'd0;
                        write_count   <= 18'd0;
                        timeout_error <= 1'b0;
                        range_error   <= 1'b0;
                        sequence_busy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ram_wren && write_count != COUNT_MAX) begin
                        write_count <= write_count + 18'd1;
                    end
                    if (bus_wren && !addr_in_range) begin
                        range_error <= 1'b1;
                    end
                    // done takes priority over a watchdog expiring on the same edge
                    if (done_hit) begin
                        state       <= ST_GAP;
                        pass_enable <= '0;
                        hold_cycle  <= 1'b0;
                    end else if (watchdog_expired) begin
                        state         <= ST_ABORT;
                        pass_enable   <= '0;
                        timeout_error <= 1'b1;
                        hold_cycle    <= 1'b0;
                    end else begin
                        watchdog <= watchdog + 24'd1;
                    end
                end
                ST_GAP: begin
                    if (!hold_cycle) begin
                        hold_cycle <= 1'b1;
                    end else if (current_pass == LAST_PASS) begin
                        state         <= ST_FINISHED;
                        sequence_done <= 1'b1;
                    end else begin
                        state        <= ST_RUN;
                        current_pass <= current_pass + 8'd1;
                        pass_enable  <= NUM_PASSES'(1) << (current_pass + 8'd1);
                        watchdog     <= 24'd0;
                    end
                end
                ST_FINISHED: begin
                    state         <= ST_IDLE;
                    sequence_busy <= 1'b0;
                end
                ST_ABORT: begin
                    if (!hold_cycle) begin
                        hold_cycle <= 1'b1;
                    end else begin
                        state         <= ST_IDLE;
                        sequence_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pass_memory_server.md
# pass_memory_server

Memory-side counterpart to the image-processing passes (pixel filling, edge cleanup, etc.). It sequences the passes one at a time through a one-hot enable/done handshake. While a pass is enabled, it forwards that pass's read/write requests to the single image RAM port and returns read data. It sits between the pass modules and the 320x240 word-per-pixel image RAM, owning the RAM port and guarding it against runaway passes and out-of-range writes.

## Interface
Parameters:
- NUM_PASSES, 4, number of passes sequenced, index 0 first
- IMAGE_WORDS, 76800, valid RAM word count; writes at or above this address are blocked
- TIMEOUT_CYCLES, 24'd1000000, maximum cycles a single pass may stay enabled

Ports:
- clk_div_by_two  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that starts a sequence; ignored unless in IDLE
- pass_enable  out  NUM_PASSES  one-hot enable to the passes
- pass_done  in  NUM_PASSES  done flags from the passes
- bus_wren  in  1  write strobe from the enabled pass
- bus_address  in  18  word address from the enabled pass
- bus_data_write  in  32  write data from the enabled pass
- ram_wren  out  1  RAM write enable
- ram_address  out  18  RAM address
- ram_data_write  out  32  RAM write data
- ram_data_read  in  32  RAM read data; synchronous RAM, one-cycle latency
- data_read  out  32  read data returned to the passes
- current_pass  out  8  index of the pass in progress
- sequence_busy  out  1  high from sequence start until return to IDLE
- sequence_done  out  1  one-cycle pulse when all passes complete normally
- write_count  out  18  forwarded writes in this sequence; saturates at 18'h3FFFF
- timeout_error  out  1  sticky flag; cleared on an accepted start
- range_error  out  1  sticky flag; cleared on an accepted start

## Operation
- States: IDLE, RUN, GAP, FINISHED, ABORT.
- IDLE:
  - pass_enable=0, sequence_busy=0.
  - start=1 → RUN, with current_pass=0, watchdog=0, write_count=0, timeout_error=0, range_error=0.
- RUN:
  - pass_enable = 1<<current_pass (registered); sequence_busy=1.
  - Watchdog increments each cycle.
  - pass_done[current_pass]=1 → GAP. Done bits of other passes are ignored.
  - Watchdog reaching TIMEOUT_CYCLES-1 with no done → timeout_error=1, go to ABORT.
  - If done and timeout occur in the same cycle, done wins.
- GAP: pass_enable=0 for exactly 2 cycles, so the pass sees enable low and clears its done flag. Then:
  - if current_pass == NUM_PASSES-1 → FINISHED;
  - otherwise current_pass+1 → RUN with watchdog=0.
- FINISHED: sequence_done=1 for one cycle → IDLE.
- ABORT: pass_enable=0 for 2 cycles → IDLE. sequence_done stays 0.
- Bus forwarding (combinational, RUN only):
  - ram_address=bus_address; ram_data_write=bus_data_write.
  - ram_wren = bus_wren & (bus_address < IMAGE_WORDS).
  - data_read = ram_data_read in all states.
- Outside RUN: ram_wren=0, ram_address=0, ram_data_write=0.
- Range check: bus_wren=1 with bus_address >= IMAGE_WORDS in RUN → write suppressed, range_error=1 on the next edge.
- write_count increments on each RUN cycle where ram_wren=1, saturating at 18'h3FFFF.
- Reset (any time, including mid-pass): state=IDLE and every registered output zero: pass_enable, current_pass, sequence_busy, sequence_done, write_count, timeout_error, range_error. Combinational RAM outputs fall to 0 as a result.

## Timing
- start sampled at edge N → pass_enable[0]=1 and sequence_busy=1 after edge N.
- Read latency seen by a pass: address presented in cycle K → data_read valid in cycle K+1. No added register stage.
- Writes land in the RAM on the same edge bus_wren is sampled.
- pass_done sampled at edge M → pass_enable low after M. Next pass enabled after M+2.
- Last pass done at edge M → sequence_done high during cycle M+2 to M+3, sequence_busy low after M+3.
- Timeout: pass_enable drops TIMEOUT_CYCLES cycles after it rose.
- start during a sequence has no effect.

## Test plan
- Nominal run with NUM_PASSES=2, passes asserting done after 10 and 20 cycles → pass_enable 2'b01, then 2'b00 for 2 cycles, then 2'b10; sequence_done pulses once; sequence_busy drops the following cycle.
- Read/write forwarding: pass writes 32'h1 to address 2240, then reads 2240 → ram_wren high for one cycle; data_read=32'h1 one cycle after the read address; write_count=1.
- Range guard: write to address 76800 → ram_wren stays 0, range_error=1 after the edge. Next start clears range_error.
- Timeout with TIMEOUT_CYCLES=16 and pass 0 never done → pass_enable drops after 16 cycles, timeout_error=1, no sequence_done, return to IDLE; a new start re-enables pass 0.
- Simultaneous events: done asserted on the timeout cycle → treated as done, timeout_error stays 0. pass_done[1] asserted while pass 0 runs → ignored.
- rst_n pulsed low mid-RUN with write in progress → all outputs 0 immediately (asynchronous); after release, block idles until start.
